// File: rtl/dff_pipeline.sv
// dff_pipeline: WIDTH-bit, DEPTH-stage enabled register chain with valid tracking,
// synchronous flush, combinational tap and registered occupancy. Optional parity via PIPE_PARITY_EN.
module dff_pipeline #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              TSW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int              OW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             valid_in,
  input  logic [TSW-1:0]   tap_sel,
`ifdef PIPE_PARITY_EN
  input  logic             perr_inject,
  output logic             parity_err,
`endif
  output logic [WIDTH-1:0] q,
  output logic             valid_out,
  output logic [WIDTH-1:0] tap,
  output logic [OW-1:0]    occupancy
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [OW-1:0]    occ_q;
  logic [OW-1:0]    occ_d;

  always_comb begin
    stage_d[0] = stage_q[0];
    valid_d[0] = valid_q[0];
    if (flush) begin
      stage_d[0] = RESET_VAL;
      valid_d[0] = 1'b0;
    end else if (en) begin
      stage_d[0] = d;
      valid_d[0] = valid_in;
    end
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
      valid_d[i] = valid_q[i];
      if (flush) begin
        stage_d[i] = RESET_VAL;
        valid_d[i] = 1'b0;
      end else if (en) begin
        stage_d[i] = stage_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  // Occupancy is derived from the next valid vector so it moves on the same edge.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Out-of-range selects (non-power-of-2 DEPTH) fall through to RESET_VAL.
  always_comb begin
    tap = RESET_VAL;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TSW'(i)) begin
        tap = stage_q[i];
      end
    end
  end

  assign q         = stage_q[DEPTH-1];
  assign valid_out = valid_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] par_d;
  logic             perr_q;
  logic             perr_d;

  always_comb begin
    par_d[0] = par_q[0];
    if (flush) begin
      par_d[0] = ^RESET_VAL;
    end else if (en) begin
      par_d[0] = (^d) ^ perr_inject;
    end
    for (int i = 1; i < DEPTH; i++) begin
      par_d[i] = par_q[i];
      if (flush) begin
        par_d[i] = ^RESET_VAL;
      end else if (en) begin
        par_d[i] = par_q[i-1];
      end
    end
  end

  // Sticky error: checks the word currently on q, cleared only by flush or reset.
  always_comb begin
    perr_d = perr_q;
    if (flush) begin
      perr_d = 1'b0;
    end else if (valid_q[DEPTH-1] && ((^stage_q[DEPTH-1]) != par_q[DEPTH-1])) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q  <= {DEPTH{^RESET_VAL}};
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`endif

endmodule
